// File: rtl/multi_clock_divider_pkg.sv
// Shared constants, channel state type and divisor clamp for multi_clock_divider.
package multi_clock_divider_pkg;

   localparam int MIN_DIV = 2;

   // Internal divisor width; the top-level CNT_W must not exceed it.
   localparam int DIV_W = 32;

   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic             pending;
   } ch_cfg_t;

   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
      return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
   endfunction

endpackage

// File: rtl/multi_clock_divider_ch.sv
// One divider channel: counter, active divisor, staged divisor and tick/square outputs.
// sync_in exists only when MULTI_CLOCK_DIVIDER_SYNC_EN is defined.
module multi_clock_divider_ch
   import multi_clock_divider_pkg::*;
#(
   parameter int CNT_W       = 26,
   parameter int DEFAULT_DIV = 50_000_000
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
   input  logic             sync_in,
`endif
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_div,
   output logic             pending,
   output logic             tick,
   output logic             sq_out
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   ch_cfg_t          cfg_q, cfg_d;
   logic [DIV_W-1:0] stg_q, stg_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             sync;
   logic             wrap;

   always_comb begin
      sync = 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      sync = sync_in;
`endif
      wrap  = enable && (DIV_W'(cnt_q) == cfg_q.div - DIV_W'(1));
      cnt_d = cnt_q;
      cfg_d = cfg_q;
      stg_d = stg_q;

      if (sync) begin
         cnt_d = '0;
         if (cfg_q.pending) begin
            cfg_d.div     = stg_q;
            cfg_d.pending = 1'b0;
         end
      end else if (enable) begin
         if (wrap) begin
            cnt_d = '0;
            // Divisor changes only on a period boundary so no period is cut short.
            if (cfg_q.pending) begin
               cfg_d.div     = stg_q;
               cfg_d.pending = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // The top only raises wr_en while pending is clear, so this never races an apply.
      if (wr_en) begin
         stg_d         = clamp_div(DIV_W'(wr_div));
         cfg_d.pending = 1'b1;
      end

      // Outputs are computed from next state so they line up with the registered count.
      tick_d = !sync && enable && (DIV_W'(cnt_d) == cfg_d.div - DIV_W'(1));
      sq_d   = DIV_W'(cnt_d) >= (cfg_d.div >> 1);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt_q         <= '0;
         cfg_q.div     <= DEF_DIV;
         cfg_q.pending <= 1'b0;
         stg_q         <= DEF_DIV;
         tick_q        <= 1'b0;
         sq_q          <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cfg_q  <= cfg_d;
         stg_q  <= stg_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign pending = cfg_q.pending;
   assign tick    = tick_q;
   assign sq_out  = sq_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH-channel programmable clock-enable divider; top holds cfg_ch decode and cfg_ready mux.
// Define MULTI_CLOCK_DIVIDER_SYNC_EN to add the sync_in phase-align strobe.
module multi_clock_divider
   import multi_clock_divider_pkg::*;
#(
   parameter int CNT_W       = 26,
   parameter int NUM_CH      = 2,
   parameter int DEFAULT_DIV = 50_000_000,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
   input  logic              sync_in,
`endif
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq_out
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] wr_en;

   // Out-of-range channel numbers match nothing: ready stays 1 and the write is dropped.
   always_comb begin
      cfg_ready = 1'b1;
      wr_en     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending[i];
            wr_en[i]  = cfg_valid & ~pending[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      multi_clock_divider_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .reset   (reset),
         .enable  (enable),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
         .sync_in (sync_in),
`endif
         .wr_en   (wr_en[g]),
         .wr_div  (cfg_div),
         .pending (pending[g]),
         .tick    (tick[g]),
         .sq_out  (sq_out[g])
      );
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed plus random bench for multi_clock_divider against a cycle-level arithmetic model.
module tb_multi_clock_divider;

   localparam int CNT_W  = 26;
   localparam int NUM_CH = 2;
   localparam int DDIV   = 10;

   logic              clk_in = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [0:0]        cfg_ch = 1'b0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq_out;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
   logic              sync_in = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int m_cnt  [NUM_CH];
   int m_div  [NUM_CH];
   int m_stg  [NUM_CH];
   bit m_pend [NUM_CH];
   bit m_tick [NUM_CH];
   bit m_sq   [NUM_CH];

   always #5 clk_in = ~clk_in;

   multi_clock_divider #(
      .CNT_W       (CNT_W),
      .NUM_CH      (NUM_CH),
      .DEFAULT_DIV (DDIV)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      .sync_in   (sync_in),
`endif
      .tick      (tick),
      .sq_out    (sq_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Reference: per channel, a position within the period and a period length in cycles.
   task automatic model_edge(input bit acc);
      bit s;
      s = 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      s = sync_in;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            m_cnt[i] = 0; m_div[i] = DDIV; m_stg[i] = DDIV;
            m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
         end else begin
            if (s) begin
               if (m_pend[i]) begin m_div[i] = m_stg[i]; m_pend[i] = 0; end
               m_cnt[i] = 0;
            end else if (enable) begin
               if (m_cnt[i] == m_div[i] - 1) begin
                  m_cnt[i] = 0;
                  if (m_pend[i]) begin m_div[i] = m_stg[i]; m_pend[i] = 0; end
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
            if (acc && int'(cfg_ch) == i) begin
               m_stg[i]  = (cfg_div < 2) ? 2 : int'(cfg_div);
               m_pend[i] = 1;
            end
            m_tick[i] = !s && enable && (m_cnt[i] == m_div[i] - 1);
            m_sq[i]   = m_cnt[i] >= m_div[i] / 2;
         end
      end
   endtask

   task automatic step(output bit acc);
      bit exp_rdy;
      #1;
      exp_rdy = !m_pend[int'(cfg_ch)];
      chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, exp_rdy});
      acc = cfg_valid && exp_rdy && !reset;
      @(posedge clk_in);
      model_edge(acc);
      #1;
      cyc++;
      for (int i = 0; i < NUM_CH; i++) begin
         chk($sformatf("tick[%0d]", i), {31'b0, tick[i]}, {31'b0, m_tick[i]});
         chk($sformatf("sq_out[%0d]", i), {31'b0, sq_out[i]}, {31'b0, m_sq[i]});
      end
   endtask

   task automatic run(input int n);
      bit a;
      for (int k = 0; k < n; k++) step(a);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run(2);
      reset  = 1'b0;
      enable = 1'b1;
      cyc    = 0;
   endtask

   task automatic cfg_write(input int ch, input int dv);
      bit acc;
      acc       = 1'b0;
      cfg_valid = 1'b1;
      cfg_ch    = 1'(ch);
      cfg_div   = CNT_W'(dv);
      for (int k = 0; k < 64 && !acc; k++) step(acc);
      cfg_valid = 1'b0;
      chk("cfg_write_accept", {31'b0, acc}, 32'd1);
   endtask

   task automatic check_default_restart();
      for (int k = 0; k < 30; k++) begin
         run(1);
         chk("rst_tick_pattern", {30'b0, tick}, (cyc % DDIV == DDIV - 1) ? 32'd3 : 32'd0);
         chk("rst_sq_pattern", {30'b0, sq_out}, (cyc % DDIV >= DDIV / 2) ? 32'd3 : 32'd0);
      end
   endtask

   initial begin
      bit a;
      @(posedge clk_in);
      model_edge(1'b0);
      #1;
      do_reset();
      chk("reset_tick", {30'b0, tick}, 32'd0);
      chk("reset_sq", {30'b0, sq_out}, 32'd0);
      chk("reset_ready", {31'b0, cfg_ready}, 32'd1);
      check_default_restart();

      // ch1 -> 4 mid-period: finishes its 10-cycle period (tick at 39) then every 4.
      run(3);
      cfg_write(1, 4);
      for (int k = 0; k < 20; k++) begin
         run(1);
         chk("ch1_new_rate", {31'b0, tick[1]},
             (cyc == 39 || (cyc > 39 && (cyc - 39) % 4 == 0)) ? 32'd1 : 32'd0);
         chk("ch0_unaffected", {31'b0, tick[0]}, (cyc % 10 == 9) ? 32'd1 : 32'd0);
      end

      cfg_write(0, 0);
      cfg_write(1, 1);
      run(20);
      cfg_write(0, 5);
      run(20);

      run(3);
      enable = 1'b0;
      run(7);
      enable = 1'b1;
      run(15);

      for (int k = 0; k < 400; k++) begin
         enable    = ($urandom % 8) != 0;
         cfg_valid = ($urandom % 4) == 0;
         cfg_ch    = 1'($urandom % 2);
         cfg_div   = CNT_W'($urandom_range(0, 9));
         reset     = ($urandom % 150) == 0;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
         sync_in   = ($urandom % 40) == 0;
`endif
         step(a);
      end
      cfg_valid = 1'b0;
      reset     = 1'b0;
      enable    = 1'b1;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      sync_in   = 1'b0;
`endif
      run(13);

      do_reset();
      chk("midreset_tick", {30'b0, tick}, 32'd0);
      chk("midreset_sq", {30'b0, sq_out}, 32'd0);
      check_default_restart();

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      cfg_write(0, 7);
      cfg_write(1, 3);
      run(25);
      cfg_write(1, 6);
      sync_in = 1'b1;
      run(2);
      sync_in = 1'b0;
      cyc = 0;
      for (int k = 0; k < 24; k++) begin
         run(1);
         chk("sync_ch0_tick", {31'b0, tick[0]}, (cyc % 7 == 6) ? 32'd1 : 32'd0);
         chk("sync_ch1_tick", {31'b0, tick[1]}, (cyc % 6 == 5) ? 32'd1 : 32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
